vote_tally: RTL and testbench

- Consumer end of the per-candidate `valid_vote` pulse interface; each candidate's debounced button logic drives one single-cycle `valid_vote` pulse per press.
- Tallies accepted votes per candidate and rejects ambiguous (simultaneous) presses.
- Enforces a post-vote lockout so one voter cannot cast back-to-back votes.
- In result mode, presents the count of a selected candidate to the display/LED logic.

---
 rtl/vote_pkg.sv | 38 +++
 rtl/vote_lockout_timer.sv | 30 +++
 rtl/vote_tally.sv | 123 ++++++++++++
 tb/tb_vote_tally.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block: FSM states, default sizing
// and the one-hot decoder used to spot ambiguous presses.
package vote_pkg;

  typedef enum logic [1:0] {
    VOTE_IDLE   = 2'd0,
    VOTE_LOCK   = 2'd1,
    VOTE_RESULT = 2'd2
  } vote_state_t;

  localparam int VOTE_NUM_CAND = 4;
  localparam int VOTE_CNT_W    = 8;

  // The decoder works on a fixed wide vector so any NUM_CAND up to 32 can share it.
  localparam int VOTE_MAX_CAND  = 32;
  localparam int VOTE_MAX_IDX_W = 5;

  typedef struct packed {
    logic                      single;
    logic [VOTE_MAX_IDX_W-1:0] idx;
  } onehot_t;

  function automatic onehot_t onehot_check(input logic [VOTE_MAX_CAND-1:0] vec);
    onehot_t     res;
    int unsigned hits;
    res  = '0;
    hits = 0;
    for (int i = 0; i < VOTE_MAX_CAND; i++) begin
      if (vec[i]) begin
        hits++;
        res.idx = VOTE_MAX_IDX_W'(i);
      end
    end
    res.single = (hits == 1);
    return res;
  endfunction

endpackage

// File: rtl/vote_lockout_timer.sv
// Loadable down-counter that holds busy high for LOCKOUT_CYCLES cycles after
// each load.
module vote_lockout_timer
  import vote_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic [TW-1:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= TW'(LOCKOUT_CYCLES);
    end else if (remaining != '0) begin
      remaining <= remaining - TW'(1);
    end
  end

  assign busy = (remaining != '0);

endmodule

// File: rtl/vote_tally.sv
// Per-candidate vote counter with ambiguity rejection, saturation, post-vote
// lockout and a registered result readout.
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND       = VOTE_NUM_CAND,
  parameter int CNT_W          = VOTE_CNT_W,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic [NUM_CAND-1:0]              valid_vote,
  input  logic [$clog2(NUM_CAND)-1:0]      sel,
  output logic                             vote_accepted,
  output logic                             vote_rejected,
  output logic                             busy,
  output logic [CNT_W-1:0]                 result_count,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0] total_votes,
  output logic                             in_result
);

  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + IDX_W;

  vote_state_t      state;
  vote_state_t      next_state;
  logic [CNT_W-1:0] count [NUM_CAND];
  logic [TOT_W-1:0] total_q;
  logic [CNT_W-1:0] result_q;
  logic             accepted_q;
  logic             rejected_q;
  onehot_t          vote_oh;
  logic [IDX_W-1:0] vote_idx;
  logic             lock_busy;
  logic             take_vote;
  logic             refuse_vote;
  logic             unused_idx_bits;

  always_comb begin
    vote_oh = onehot_check(VOTE_MAX_CAND'(valid_vote));
  end

  assign vote_idx        = vote_oh.idx[IDX_W-1:0];
  assign unused_idx_bits = ^vote_oh.idx;

  vote_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout (
    .clk  (clk),
    .reset(reset),
    .load (take_vote),
    .busy (lock_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= VOTE_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // LOCK behaves as IDLE in the cycle its timer has run out, so busy and the
  // refusal window line up exactly.
  always_comb begin
    next_state  = state;
    take_vote   = 1'b0;
    refuse_vote = 1'b0;
    case (state)
      VOTE_RESULT: begin
        if (!mode) begin
          next_state = VOTE_IDLE;
        end
      end
      default: begin
        if (state == VOTE_LOCK && lock_busy) begin
          next_state = VOTE_LOCK;
        end else if (mode) begin
          next_state = VOTE_RESULT;
        end else if (valid_vote != '0) begin
          if (vote_oh.single && (count[vote_idx] != {CNT_W{1'b1}})) begin
            take_vote  = 1'b1;
            next_state = VOTE_LOCK;
          end else begin
            refuse_vote = 1'b1;
            next_state  = VOTE_IDLE;
          end
        end else begin
          next_state = VOTE_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        count[i] <= '0;
      end
      total_q    <= '0;
      result_q   <= '0;
      accepted_q <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      accepted_q <= take_vote;
      rejected_q <= refuse_vote;
      if (take_vote) begin
        count[vote_idx] <= count[vote_idx] + CNT_W'(1);
        total_q         <= total_q + TOT_W'(1);
      end
      result_q <= (next_state == VOTE_RESULT) ? count[sel] : '0;
    end
  end

  assign vote_accepted = accepted_q;
  assign vote_rejected = rejected_q;
  assign busy          = lock_busy;
  assign result_count  = result_q;
  assign total_votes   = total_q;
  assign in_result     = (state == VOTE_RESULT);

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally with 2-bit counters so saturation is reachable;
// expected values are hand-computed per step.
module tb_vote_tally;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [3:0] valid_vote;
  logic [1:0] sel;
  logic       vote_accepted;
  logic       vote_rejected;
  logic       busy;
  logic [1:0] result_count;
  logic [3:0] total_votes;
  logic       in_result;

  int checks = 0;
  int errors = 0;

  vote_tally #(
    .NUM_CAND      (4),
    .CNT_W         (2),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .valid_vote   (valid_vote),
    .sel          (sel),
    .vote_accepted(vote_accepted),
    .vote_rejected(vote_rejected),
    .busy         (busy),
    .result_count (result_count),
    .total_votes  (total_votes),
    .in_result    (in_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic m, input logic [3:0] v, input logic [1:0] s);
    mode       = m;
    valid_vote = v;
    sel        = s;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check_output("lock_end", 32'(busy), 32'd0);
  endtask

  // Accept one vote on candidate bit v, then let the lockout drain.
  task automatic cast_vote(input logic [3:0] v, input logic [31:0] exp_total);
    apply_stimulus(1'b0, v, 2'd0);
    tick();
    check_output("cast_accept", 32'(vote_accepted), 32'd1);
    check_output("cast_total", 32'(total_votes), exp_total);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    wait_idle();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_total", 32'(total_votes), 32'd0);
    check_output("rst_acc", 32'(vote_accepted), 32'd0);
    check_output("rst_rej", 32'(vote_rejected), 32'd0);
    check_output("rst_in_result", 32'(in_result), 32'd0);
    check_output("rst_result", 32'(result_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // First vote on candidate 1 and exact lockout length
    apply_stimulus(1'b0, 4'b0010, 2'd0);
    tick();
    check_output("v1_acc", 32'(vote_accepted), 32'd1);
    check_output("v1_rej", 32'(vote_rejected), 32'd0);
    check_output("v1_total", 32'(total_votes), 32'd1);
    check_output("v1_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();
    check_output("v1_acc_pulse", 32'(vote_accepted), 32'd0);
    apply_stimulus(1'b0, 4'b0001, 2'd0);
    tick();
    check_output("lock_acc", 32'(vote_accepted), 32'd0);
    check_output("lock_rej", 32'(vote_rejected), 32'd0);
    check_output("lock_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    n = 3;
    while (busy && n < 40) begin
      tick();
      if (busy) n++;
    end
    check_output("busy_len", 32'(n), 32'd16);
    check_output("lock_total", 32'(total_votes), 32'd1);
    tick();
    check_output("lock_ignored_acc", 32'(vote_accepted), 32'd0);

    // Ambiguous press
    apply_stimulus(1'b0, 4'b0101, 2'd0);
    tick();
    check_output("amb_rej", 32'(vote_rejected), 32'd1);
    check_output("amb_acc", 32'(vote_accepted), 32'd0);
    check_output("amb_busy", 32'(busy), 32'd0);
    check_output("amb_total", 32'(total_votes), 32'd1);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();
    check_output("amb_rej_pulse", 32'(vote_rejected), 32'd0);

    // Saturate candidate 3 at 3
    cast_vote(4'b1000, 32'd2);
    cast_vote(4'b1000, 32'd3);
    cast_vote(4'b1000, 32'd4);
    apply_stimulus(1'b0, 4'b1000, 2'd0);
    tick();
    check_output("sat_rej", 32'(vote_rejected), 32'd1);
    check_output("sat_acc", 32'(vote_accepted), 32'd0);
    check_output("sat_busy", 32'(busy), 32'd0);
    check_output("sat_total", 32'(total_votes), 32'd4);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();

    // Candidate 0 twice, candidate 2 once
    cast_vote(4'b0001, 32'd5);
    cast_vote(4'b0001, 32'd6);
    cast_vote(4'b0100, 32'd7);

    // Result mode readout
    apply_stimulus(1'b1, 4'b0000, 2'd0);
    tick();
    check_output("res_in_result", 32'(in_result), 32'd1);
    check_output("res_sel0", 32'(result_count), 32'd2);
    apply_stimulus(1'b1, 4'b0000, 2'd2);
    check_output("res_sel_latency", 32'(result_count), 32'd2);
    tick();
    check_output("res_sel2", 32'(result_count), 32'd1);
    apply_stimulus(1'b1, 4'b0000, 2'd1);
    tick();
    check_output("res_sel1", 32'(result_count), 32'd1);
    apply_stimulus(1'b1, 4'b0001, 2'd3);
    tick();
    check_output("res_sel3", 32'(result_count), 32'd3);
    check_output("res_vote_acc", 32'(vote_accepted), 32'd0);
    check_output("res_vote_rej", 32'(vote_rejected), 32'd0);
    check_output("res_vote_total", 32'(total_votes), 32'd7);
    apply_stimulus(1'b1, 4'b0000, 2'd0);
    tick();
    check_output("res_sel0_again", 32'(result_count), 32'd2);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();
    check_output("leave_in_result", 32'(in_result), 32'd0);
    check_output("leave_result", 32'(result_count), 32'd0);

    // mode is ignored during lockout, honoured in the first idle cycle after
    apply_stimulus(1'b0, 4'b0010, 2'd0);
    tick();
    check_output("v8_acc", 32'(vote_accepted), 32'd1);
    apply_stimulus(1'b1, 4'b0000, 2'd1);
    tick();
    check_output("lock_mode_in_result", 32'(in_result), 32'd0);
    wait_idle();
    check_output("lock_mode_still_idle", 32'(in_result), 32'd0);
    tick();
    check_output("post_lock_in_result", 32'(in_result), 32'd1);
    check_output("post_lock_sel1", 32'(result_count), 32'd2);
    check_output("post_lock_total", 32'(total_votes), 32'd8);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();

    // Asynchronous reset in the middle of a lockout
    apply_stimulus(1'b0, 4'b0100, 2'd0);
    tick();
    check_output("pre_rst_total", 32'(total_votes), 32'd9);
    apply_stimulus(1'b0, 4'b0000, 2'd0);
    tick();
    check_output("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_total", 32'(total_votes), 32'd0);
    #2;
    reset = 1'b1;
    apply_stimulus(1'b1, 4'b0000, 2'd2);
    tick();
    check_output("after_rst_in_result", 32'(in_result), 32'd1);
    check_output("after_rst_count2", 32'(result_count), 32'd0);
    apply_stimulus(1'b1, 4'b0000, 2'd3);
    tick();
    check_output("after_rst_count3", 32'(result_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
